// File: rtl/adder_pipe.sv
// Carry-chained pipelined adder built from NIBBLES registered 4-bit slices,
// latency NIBBLES enabled edges. Optional saturation via macro ADDER_PIPE_SAT_EN.
module adder_pipe #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   c_in,
  input  logic                   b_inv,
  input  logic                   sat,
  output logic                   out_valid,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   c_out,
  output logic                   ovf,
  output logic                   zero
);

  localparam int W = 4 * NIBBLES;

  // Stage k holds an op whose nibbles 0..k are resolved; the operand vectors
  // travel alongside so later nibbles are consumed one stage at a time.
  logic         valid_reg  [NIBBLES];
  logic         carry_reg  [NIBBLES];
  logic         sat_reg    [NIBBLES];
  logic [W-1:0] opa_reg    [NIBBLES];
  logic [W-1:0] opb_reg    [NIBBLES];
  logic [W-1:0] res_reg    [NIBBLES];
  logic         msbc_reg;

  logic         valid_next [NIBBLES];
  logic         carry_next [NIBBLES];
  logic         sat_next   [NIBBLES];
  logic [W-1:0] opa_next   [NIBBLES];
  logic [W-1:0] opb_next   [NIBBLES];
  logic [W-1:0] res_next   [NIBBLES];
  logic         msbc_next;

  logic [W-1:0] b_eff;
  assign b_eff = b_inv ? ~b : b;

  genvar gi;
  generate
    for (gi = 0; gi < NIBBLES; gi++) begin : g_slice
      logic [W-1:0] a_k;
      logic [W-1:0] b_k;
      logic [W-1:0] res_prev;
      logic         cin_k;
      logic         sat_k;
      logic         valid_k;
      logic [4:0]   slice_sum;

      if (gi == 0) begin : g_head
        assign a_k      = a;
        assign b_k      = b_eff;
        assign res_prev = '0;
        assign cin_k    = c_in;
        assign sat_k    = sat;
        assign valid_k  = in_valid;
      end else begin : g_body
        assign a_k      = opa_reg[gi-1];
        assign b_k      = opb_reg[gi-1];
        assign res_prev = res_reg[gi-1];
        assign cin_k    = carry_reg[gi-1];
        assign sat_k    = sat_reg[gi-1];
        assign valid_k  = valid_reg[gi-1];
      end

      assign slice_sum = {1'b0, a_k[4*gi +: 4]} + {1'b0, b_k[4*gi +: 4]} + {4'b0000, cin_k};

      assign res_next[gi]   = res_prev | (W'(slice_sum[3:0]) << (4*gi));
      assign carry_next[gi] = slice_sum[4];
      assign opa_next[gi]   = a_k;
      assign opb_next[gi]   = b_k;
      assign sat_next[gi]   = sat_k;
      assign valid_next[gi] = valid_k & ~flush;

      // Carry into the MSB recovered from the MSB's own sum bit.
      if (gi == NIBBLES - 1) begin : g_tail
        assign msbc_next = a_k[W-1] ^ b_k[W-1] ^ slice_sum[3];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NIBBLES; i++) begin
        valid_reg[i] <= 1'b0;
        carry_reg[i] <= 1'b0;
        sat_reg[i]   <= 1'b0;
        opa_reg[i]   <= '0;
        opb_reg[i]   <= '0;
        res_reg[i]   <= '0;
      end
      msbc_reg <= 1'b0;
    end else if (en) begin
      for (int i = 0; i < NIBBLES; i++) begin
        valid_reg[i] <= valid_next[i];
        carry_reg[i] <= carry_next[i];
        sat_reg[i]   <= sat_next[i];
        opa_reg[i]   <= opa_next[i];
        opb_reg[i]   <= opb_next[i];
        res_reg[i]   <= res_next[i];
      end
      msbc_reg <= msbc_next;
    end
  end

  logic [W-1:0] raw_sum;
  logic         raw_ovf;
  logic [W-1:0] final_sum;
  logic         unused_bits;
  logic         emit;

  assign raw_sum = res_reg[NIBBLES-1];
  assign raw_ovf = carry_reg[NIBBLES-1] ^ msbc_reg;
  assign emit    = valid_reg[NIBBLES-1] & ~flush;

`ifdef ADDER_PIPE_SAT_EN
  // Overflow direction is read from the wrapped sign: negative-looking means positive overflow.
  assign final_sum = (sat_reg[NIBBLES-1] && raw_ovf) ?
                     (raw_sum[W-1] ? {1'b0, {(W-1){1'b1}}} : {1'b1, {(W-1){1'b0}}}) :
                     raw_sum;
  assign unused_bits = ^{opa_reg[NIBBLES-1], opb_reg[NIBBLES-1]};
`else
  assign final_sum   = raw_sum;
  assign unused_bits = ^{sat_reg[NIBBLES-1], opa_reg[NIBBLES-1], opb_reg[NIBBLES-1]};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      c_out     <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else if (en) begin
      out_valid <= emit;
      if (emit) begin
        sum   <= final_sum;
        c_out <= carry_reg[NIBBLES-1];
        ovf   <= raw_ovf;
        zero  <= (final_sum == '0);
      end
    end
  end

endmodule

// File: tb/tb_adder_pipe.sv
// Scoreboard bench for adder_pipe: driver pushes reference results, a negedge
// monitor pops and compares each presented result, checking latency and freeze.
module tb_adder_pipe;
  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         c_in = 1'b0;
  logic         b_inv = 1'b0;
  logic         sat = 1'b0;
  logic         out_valid;
  logic [W-1:0] sum;
  logic         c_out;
  logic         ovf;
  logic         zero;

  adder_pipe #(.NIBBLES(N)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .in_valid(in_valid),
    .a(a), .b(b), .c_in(c_in), .b_inv(b_inv), .sat(sat),
    .out_valid(out_valid), .sum(sum), .c_out(c_out), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] sum;
    logic         c_out;
    logic         ovf;
    logic         zero;
    int           issue;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   edge_cnt = 0;
  int   n_out = 0;
  bit   last_en = 1'b0;
  bit   have_prev = 1'b0;
  logic [W+3:0] prev_out;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s got=%h want=%h at t=%0t", name, got, expv, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the full-width operands.
  function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                                 input logic tc, input logic ti, input logic ts);
    exp_t   e;
    logic [W-1:0] bb;
    longint ua, ub, full, sa, sb, sr, lim;
    bb   = ti ? ~tb_ : tb_;
    ua   = longint'(ta);
    ub   = longint'(bb);
    full = ua + ub + longint'(tc);
    e.sum   = full[W-1:0];
    e.c_out = full[W];
    lim  = longint'(1) << (W - 1);
    sa   = ta[W-1] ? ua - 2 * lim : ua;
    sb   = bb[W-1] ? ub - 2 * lim : ub;
    sr   = sa + sb + longint'(tc);
    e.ovf = (sr >= lim) || (sr < -lim);
`ifdef ADDER_PIPE_SAT_EN
    if (ts && e.ovf) e.sum = (sr > 0) ? {1'b0, {(W-1){1'b1}}} : {1'b1, {(W-1){1'b0}}};
`else
    if (ts) e.sum = e.sum;
`endif
    e.zero  = (e.sum == '0);
    e.issue = 0;
    return e;
  endfunction

  task automatic cyc(input logic v, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                     input logic tc, input logic ti, input logic ts,
                     input logic te, input logic tf);
    exp_t e;
    in_valid = v; a = ta; b = tb_; c_in = tc; b_inv = ti; sat = ts; en = te; flush = tf;
    @(posedge clk);
    last_en = te;
    if (te) begin
      edge_cnt++;
      if (tf) q.delete();
      else if (v && rst_n) begin
        e = model(ta, tb_, tc, ti, ts);
        e.issue = edge_cnt;
        q.push_back(e);
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      have_prev = 1'b0;
    end else begin
      if (last_en) begin
        if (out_valid) begin
          if (q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_out got=%h want=no_result", sum);
          end else begin
            e = q.pop_front();
            n_out++;
            $display("result %0d: sum=%h c=%b v=%b z=%b | want sum=%h c=%b v=%b z=%b lat=%0d",
                     n_out, sum, c_out, ovf, zero, e.sum, e.c_out, e.ovf, e.zero, edge_cnt - e.issue);
            check("sum", 32'(sum), 32'(e.sum));
            check("c_out", 32'(c_out), 32'(e.c_out));
            check("ovf", 32'(ovf), 32'(e.ovf));
            check("zero", 32'(zero), 32'(e.zero));
            check("latency", 32'(edge_cnt - e.issue), 32'(N));
          end
        end
      end else if (have_prev) begin
        check("frozen", 32'({out_valid, sum, c_out, ovf, zero}), 32'(prev_out));
      end
      prev_out  = {out_valid, sum, c_out, ovf, zero};
      have_prev = 1'b1;
    end
  end

  initial begin
    #2;
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_sum", 32'(sum), 32'(0));
    check("rst_c_out", 32'(c_out), 32'(0));
    check("rst_ovf", 32'(ovf), 32'(0));
    check("rst_zero", 32'(zero), 32'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed cases
    cyc(1'b1, 16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 16'h8000, 16'h0001, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(N + 2);

    // Back-to-back with a 3-cycle stall in the middle
    cyc(1'b1, 16'h0F0F, 16'h00F1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 16'hABCD, 16'h1111, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 16'hDEAD, 16'hBEEF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'h8001, 16'h8001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(N + 2);

    // Flush with ops in flight; the op on the flush edge is discarded too
    for (int i = 0; i < 3; i++) cyc(1'b1, 16'h1000 + 16'(i), 16'h0100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 16'h4444, 16'h4444, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("flush_out_valid", 32'(out_valid), 32'(0));
    idle(N + 2);

    // Async reset while a result is being presented
    for (int i = 0; i < N + 1; i++) cyc(1'b1, 16'h2222, 16'(i), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1 rst_n = 1'b0;
    q.delete();
    #1;
    check("arst_out_valid", 32'(out_valid), 32'(0));
    check("arst_sum", 32'(sum), 32'(0));
    check("arst_c_out", 32'(c_out), 32'(0));
    idle(2);
    rst_n = 1'b1;
    cyc(1'b1, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(N + 2);

    // Randomised traffic with stalls and occasional flushes
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom),
          1'($urandom), 1'($urandom), 1'($urandom),
          1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 39) == 0));
    end
    idle(N + 2);
    check("drain_empty", 32'(q.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adder_pipe.md
ADDER_PIPE -- requirements
Module: adder_pipe

Interface
REQ-001 SHALL have parameter: NIBBLES, default 4, number of 4-bit adder slices (legal >= 1); W = 4*NIBBLES.
REQ-002 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: en  in  1  clock enable; pipeline advances only on edges with en=1.
REQ-005 SHALL have port: flush  in  1  synchronous clear of all in-flight operations (valid bits only).
REQ-006 SHALL have ports: in_valid  in  1, a  in  W, b  in  W, c_in  in  1, b_inv  in  1 (invert b), sat  in  1 (saturate request).
REQ-007 SHALL have ports: out_valid  out  1, sum  out  W, c_out  out  1 (carry out of MSB), ovf  out  1 (signed overflow), zero  out  1 (sum==0).

Function
REQ-008 SHALL compute a + (b_inv ? ~b : b) + c_in, modulo 2^W; subtract = b_inv=1, c_in=1.
REQ-009 SHALL implement NIBBLES registered 4-bit slices; slice k adds nibble k plus the registered carry of slice k-1; slice 0 uses c_in.
REQ-010 SHALL skew operand nibbles into, and deskew result nibbles out of, the slice chain so each operation's nibbles meet their own carry.
REQ-011 SHALL, for operands sampled on enabled edge E with in_valid=1, update sum/c_out/ovf/zero and assert out_valid on enabled edge E+NIBBLES (default: 4 enabled edges later).
REQ-012 SHALL accept a new operation on every enabled edge (throughput 1/enabled cycle, no back-pressure).
REQ-013 SHALL hold out_valid high for exactly one enabled cycle per operation; out_valid=0 on edges whose slot carried no valid operation.
REQ-014 SHALL, when en=0, hold every register (data, carries, valid, outputs) unchanged.
REQ-015 SHALL compute ovf = carry into MSB XOR carry out of MSB; zero from the final (post-saturation) sum.
REQ-016 SHALL, when flush=1 on an enabled edge, clear all valid bits and out_valid; an operation presented on that same edge is discarded.
REQ-017 SHALL give flush priority over in_valid and en=0 irrelevant to rst_n (rst_n overrides all).
REQ-018 SHALL keep data registers of non-valid slots don't-care but outputs sum/c_out/ovf/zero SHALL update only when out_valid is asserted.
REQ-019 SHALL produce results in issue order; c_out of each op SHALL not depend on any neighbouring op.

Reset
REQ-020 SHALL, while rst_n=0, force immediately: out_valid=0, sum=0, c_out=0, ovf=0, zero=0, all slice carries and valid bits 0.
REQ-021 SHALL discard all in-flight operations on reset mid-operation; first result after release appears NIBBLES enabled edges after first accepted op.

Configuration
REQ-022 SHALL support macro ADDER_PIPE_SAT_EN: when defined, sat is carried with the op and, if sat=1 and ovf=1, sum clamps to 0111..1 (positive overflow) or 1000..0 (negative overflow).
REQ-023 SHALL, with ADDER_PIPE_SAT_EN defined, report raw ovf and raw c_out regardless of clamping.
REQ-024 SHALL, without ADDER_PIPE_SAT_EN, keep port sat present but ignored; sum is always the raw modular result.

Verification (NIBBLES=4, W=16)
REQ-025 SHALL cover: a=0x1234, b=0x4321, c_in=0, b_inv=0 -> 4 enabled edges later sum=0x5555, c_out=0, ovf=0, zero=0, out_valid pulse 1 cycle.
REQ-026 SHALL cover: a=0xFFFF, b=0x0001, c_in=0 -> sum=0x0000, c_out=1, ovf=0, zero=1.
REQ-027 SHALL cover: a=0x0005, b=0x0007, b_inv=1, c_in=1 -> sum=0xFFFE, c_out=0, ovf=0.
REQ-028 SHALL cover: a=0x7FFF, b=0x0001, sat=1 -> with macro sum=0x7FFF, ovf=1; without macro sum=0x8000, ovf=1.
REQ-029 SHALL cover: four back-to-back ops with en=0 for 3 cycles mid-stream -> four results in order, outputs frozen during en=0, total latency 4 enabled edges each.
REQ-030 SHALL cover: rst_n low (async) and, separately, flush=1 with 3 ops in flight -> out_valid=0, no stale result emerges afterwards.
